regfile_access_ctrl: RTL and testbench

REGFILE_ACCESS_CTRL -- requirements
Module: regfile_access_ctrl

---
 rtl/regfile_access_ctrl_pkg.sv | 17 +
 rtl/regfile_addr_resolve.sv | 30 +++
 rtl/regfile_access_ctrl.sv | 127 ++++++++++++
 tb/tb_regfile_access_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared memory-map header for the register-file access controller:
// sequencer state encodings and the INDF address constant.
package regfile_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_READ    = 3'd2,
    ST_WAIT_WD = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Core address 0 selects the indirect register (INDF)
  localparam logic [6:0] INDF_ADDR = 7'h00;

endpackage

// File: rtl/regfile_addr_resolve.sv
// Combinational address resolution: banked direct, FSR-indirect, or raw debug
// address, plus detection of an indirect access that points back at INDF.
module regfile_addr_resolve
  import regfile_access_ctrl_pkg::*;
(
  input  logic       sel_dbg,
  input  logic [6:0] core_addr7,
  input  logic [1:0] status_rp,
  input  logic       status_irp,
  input  logic [7:0] fsr,
  input  logic [8:0] dbg_addr,
  output logic [8:0] res_addr,
  output logic       indf_loop
);

  always_comb begin
    res_addr  = 9'h000;
    indf_loop = 1'b0;
    if (sel_dbg) begin
      res_addr = dbg_addr;
    end else if (core_addr7 == INDF_ADDR) begin
      res_addr  = {status_irp, fsr};
      // INDF through INDF has no real target: reads as zero, writes dropped
      indf_loop = (fsr[6:0] == INDF_ADDR);
    end else begin
      res_addr = {status_rp, core_addr7};
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Sequences one core or debug access to the register file at a time:
// grant/resolve, optional read, optional write, then a completion pulse.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       core_req,
  input  logic [6:0] core_addr7,
  input  logic       core_rd,
  input  logic       core_wr,
  input  logic [7:0] core_wdata,
  input  logic       core_wdata_vld,
  output logic [7:0] core_rdata,
  output logic       core_rvld,
  output logic       core_done,
  input  logic [1:0] status_rp,
  input  logic       status_irp,
  input  logic [7:0] fsr,
  input  logic       dbg_req,
  input  logic [8:0] dbg_addr,
  input  logic       dbg_we,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_ack,
  output logic [7:0] dbg_rdata,
  output logic [8:0] rf_addr,
  output logic       rf_wr_en,
  output logic [7:0] rf_data_in,
  input  logic [7:0] rf_data_out
);

  state_t     state, state_nxt;
  logic       acc_dbg, acc_rd, acc_wr, acc_nowr;
  logic       grant, sel_dbg, indf_loop;
  logic [8:0] res_addr;
  logic [7:0] rd_val;

  // Core always wins arbitration; debug only sees the file when core is quiet
  assign sel_dbg  = !core_req;
  assign grant    = (state == ST_IDLE) && (core_req || dbg_req);
  assign rd_val   = acc_nowr ? 8'h00 : rf_data_out;
  assign rf_wr_en = (state == ST_WRITE) && !acc_nowr;

  regfile_addr_resolve u_resolve (
    .sel_dbg    (sel_dbg),
    .core_addr7 (core_addr7),
    .status_rp  (status_rp),
    .status_irp (status_irp),
    .fsr        (fsr),
    .dbg_addr   (dbg_addr),
    .res_addr   (res_addr),
    .indf_loop  (indf_loop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (grant) state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (acc_rd)      state_nxt = ST_READ;
        else if (acc_wr) state_nxt = ST_WAIT_WD;
        else             state_nxt = ST_DONE;
      end
      ST_READ:    state_nxt = acc_wr ? ST_WAIT_WD : ST_DONE;
      ST_WAIT_WD: if (acc_dbg || core_wdata_vld) state_nxt = ST_WRITE;
      ST_WRITE:   state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Access attributes and the resolved address are frozen at grant so later
  // bank/FSR changes cannot disturb an access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_addr    <= 9'h000;
      rf_data_in <= 8'h00;
      core_rdata <= 8'h00;
      core_rvld  <= 1'b0;
      core_done  <= 1'b0;
      dbg_ack    <= 1'b0;
      dbg_rdata  <= 8'h00;
      acc_dbg    <= 1'b0;
      acc_rd     <= 1'b0;
      acc_wr     <= 1'b0;
      acc_nowr   <= 1'b0;
    end else begin
      core_rvld <= 1'b0;
      core_done <= 1'b0;
      dbg_ack   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            rf_addr  <= res_addr;
            acc_dbg  <= sel_dbg;
            acc_rd   <= core_req ? core_rd : !dbg_we;
            acc_wr   <= core_req ? core_wr : dbg_we;
            acc_nowr <= indf_loop;
          end
        end
        ST_READ: begin
          if (acc_dbg) begin
            dbg_rdata <= rd_val;
          end else begin
            core_rdata <= rd_val;
            core_rvld  <= 1'b1;
          end
        end
        ST_WAIT_WD: begin
          if (acc_dbg)             rf_data_in <= dbg_wdata;
          else if (core_wdata_vld) rf_data_in <= core_wdata;
        end
        ST_DONE: begin
          core_done <= !acc_dbg;
          dbg_ack   <= acc_dbg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed self-checking bench for regfile_access_ctrl with a behavioural
// register file that samples rf_addr / rf_wr_en on the rising clock edge.
module tb_regfile_access_ctrl;

  logic       clk;
  logic       rst;
  logic       core_req;
  logic [6:0] core_addr7;
  logic       core_rd, core_wr;
  logic [7:0] core_wdata;
  logic       core_wdata_vld;
  logic [7:0] core_rdata;
  logic       core_rvld, core_done;
  logic [1:0] status_rp;
  logic       status_irp;
  logic [7:0] fsr;
  logic       dbg_req;
  logic [8:0] dbg_addr;
  logic       dbg_we;
  logic [7:0] dbg_wdata;
  logic       dbg_ack;
  logic [7:0] dbg_rdata;
  logic [8:0] rf_addr;
  logic       rf_wr_en;
  logic [7:0] rf_data_in;
  logic [7:0] rf_data_out;

  regfile_access_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .core_req       (core_req),
    .core_addr7     (core_addr7),
    .core_rd        (core_rd),
    .core_wr        (core_wr),
    .core_wdata     (core_wdata),
    .core_wdata_vld (core_wdata_vld),
    .core_rdata     (core_rdata),
    .core_rvld      (core_rvld),
    .core_done      (core_done),
    .status_rp      (status_rp),
    .status_irp     (status_irp),
    .fsr            (fsr),
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_we         (dbg_we),
    .dbg_wdata      (dbg_wdata),
    .dbg_ack        (dbg_ack),
    .dbg_rdata      (dbg_rdata),
    .rf_addr        (rf_addr),
    .rf_wr_en       (rf_wr_en),
    .rf_data_in     (rf_data_in),
    .rf_data_out    (rf_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [512];
  logic       pend_wr;
  logic [8:0] pend_addr, addr_q;
  logic [7:0] pend_data;
  int         wr_n;
  logic [8:0] last_wr_addr;
  logic [7:0] last_wr_data;

  // Register-file model: control captured mid-cycle, applied on the rising edge
  always @(negedge clk) begin
    pend_wr   = rf_wr_en;
    pend_addr = rf_addr;
    pend_data = rf_data_in;
    addr_q    = rf_addr;
  end

  always @(posedge clk) begin
    rf_data_out <= mem[addr_q];
    if (pend_wr && rst) begin
      mem[pend_addr] = pend_data;
      wr_n++;
      last_wr_addr = pend_addr;
      last_wr_data = pend_data;
    end
    pend_wr = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  int         rvld_n, rvld_cyc, done_cyc;
  logic [7:0] rvld_data;
  logic [8:0] grant_addr;

  // One core access; bank/FSR inputs are scrambled right after grant
  task automatic applyStimulus(input logic [1:0] rp, input logic irp, input logic [7:0] fsr_v,
                               input logic [6:0] a7, input logic rd, input logic wr,
                               input logic [7:0] wd, input int wd_delay);
    @(negedge clk);
    status_rp = rp; status_irp = irp; fsr = fsr_v;
    core_addr7 = a7; core_rd = rd; core_wr = wr; core_wdata = wd;
    core_wdata_vld = 1'b0; core_req = 1'b1;
    wr_n = 0; rvld_n = 0; rvld_data = 8'h00; rvld_cyc = 0; done_cyc = 0; grant_addr = 9'h000;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        grant_addr = rf_addr;
        status_rp = ~rp; status_irp = ~irp; fsr = ~fsr_v;
      end
      if (core_rvld) begin
        rvld_n++; rvld_data = core_rdata; rvld_cyc = c;
      end
      if (core_done) begin
        done_cyc = c;
        core_req = 1'b0; core_rd = 1'b0; core_wr = 1'b0; core_wdata_vld = 1'b0;
      end else if (c >= wd_delay) begin
        core_wdata_vld = 1'b1;
      end
    end
    core_req = 1'b0;
  endtask

  int core_done_c, ack_c, dbg_rvld_n, done_cnt;
  logic [7:0] arb_rdata;
  logic seen;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h0A0] = 8'h5A; mem[9'h195] = 8'hC3; mem[9'h080] = 8'h77;
    mem[9'h005] = 8'h11; mem[9'h030] = 8'h01;
    rst = 1'b1;
    core_req = 0; core_addr7 = 0; core_rd = 0; core_wr = 0; core_wdata = 0; core_wdata_vld = 0;
    status_rp = 0; status_irp = 0; fsr = 0;
    dbg_req = 0; dbg_addr = 0; dbg_we = 0; dbg_wdata = 0;
    wr_n = 0;
    #2 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_rf_addr",    32'(rf_addr),    32'h0);
    checkOutput("rst_rf_wr_en",   32'(rf_wr_en),   32'h0);
    checkOutput("rst_rf_data_in", 32'(rf_data_in), 32'h0);
    checkOutput("rst_core_rdata", 32'(core_rdata), 32'h0);
    checkOutput("rst_core_rvld",  32'(core_rvld),  32'h0);
    checkOutput("rst_core_done",  32'(core_done),  32'h0);
    checkOutput("rst_dbg_ack",    32'(dbg_ack),    32'h0);
    checkOutput("rst_dbg_rdata",  32'(dbg_rdata),  32'h0);
    rst = 1'b1;

    // Read-modify-write, write data after two idle wait cycles
    applyStimulus(2'b01, 1'b0, 8'h00, 7'h20, 1'b1, 1'b1, 8'h5B, 5);
    checkOutput("rmw_addr",      32'(grant_addr),   32'h0A0);
    checkOutput("rmw_rvld_n",    32'(rvld_n),       32'd1);
    checkOutput("rmw_rdata",     32'(rvld_data),    32'h5A);
    checkOutput("rmw_rvld_cyc",  32'(rvld_cyc),     32'd3);
    checkOutput("rmw_done_cyc",  32'(done_cyc),     32'd8);
    checkOutput("rmw_wr_n",      32'(wr_n),         32'd1);
    checkOutput("rmw_wr_addr",   32'(last_wr_addr), 32'h0A0);
    checkOutput("rmw_wr_data",   32'(last_wr_data), 32'h5B);
    checkOutput("rmw_mem",       32'(mem[9'h0A0]),  32'h5B);

    // Indirect read through FSR
    applyStimulus(2'b00, 1'b1, 8'h95, 7'h00, 1'b1, 1'b0, 8'h00, 99);
    checkOutput("ind_addr",     32'(grant_addr), 32'h195);
    checkOutput("ind_rdata",    32'(rvld_data),  32'hC3);
    checkOutput("ind_rvld_cyc", 32'(rvld_cyc),   32'd3);
    checkOutput("ind_done_cyc", 32'(done_cyc),   32'd4);
    checkOutput("ind_wr_n",     32'(wr_n),       32'd0);

    // INDF through INDF: read as zero, write suppressed, still completes
    applyStimulus(2'b00, 1'b0, 8'h80, 7'h00, 1'b1, 1'b1, 8'hFF, 3);
    checkOutput("indf_addr",     32'(grant_addr),  32'h080);
    checkOutput("indf_rvld_n",   32'(rvld_n),      32'd1);
    checkOutput("indf_rdata",    32'(rvld_data),   32'h00);
    checkOutput("indf_wr_n",     32'(wr_n),        32'd0);
    checkOutput("indf_done_cyc", 32'(done_cyc),    32'd6);
    checkOutput("indf_mem",      32'(mem[9'h080]), 32'h77);

    // Request with neither read nor write
    applyStimulus(2'b11, 1'b0, 8'h00, 7'h10, 1'b0, 1'b0, 8'h00, 99);
    checkOutput("nop_addr",     32'(grant_addr), 32'h190);
    checkOutput("nop_rvld_n",   32'(rvld_n),     32'd0);
    checkOutput("nop_wr_n",     32'(wr_n),       32'd0);
    checkOutput("nop_done_cyc", 32'(done_cyc),   32'd3);

    // Simultaneous core read and debug write: core first
    @(negedge clk);
    wr_n = 0; core_done_c = 0; ack_c = 0; arb_rdata = 8'h00;
    status_rp = 2'b00; core_addr7 = 7'h05; core_rd = 1'b1; core_wr = 1'b0; core_req = 1'b1;
    dbg_addr = 9'h120; dbg_we = 1'b1; dbg_wdata = 8'h3C; dbg_req = 1'b1;
    for (int c = 1; c <= 60 && ack_c == 0; c++) begin
      @(negedge clk);
      if (core_rvld) arb_rdata = core_rdata;
      if (core_done) begin core_done_c = c; core_req = 1'b0; core_rd = 1'b0; end
      if (dbg_ack) begin ack_c = c; dbg_req = 1'b0; end
    end
    dbg_req = 1'b0; core_req = 1'b0;
    checkOutput("arb_core_done", 32'(core_done_c),  32'd4);
    checkOutput("arb_core_data", 32'(arb_rdata),    32'h11);
    checkOutput("arb_dbg_ack",   32'(ack_c),        32'd9);
    checkOutput("arb_wr_n",      32'(wr_n),         32'd1);
    checkOutput("arb_wr_addr",   32'(last_wr_addr), 32'h120);
    checkOutput("arb_mem",       32'(mem[9'h120]),  32'h3C);

    // Debug read-back of the debug write
    @(negedge clk);
    ack_c = 0; dbg_rvld_n = 0;
    dbg_addr = 9'h120; dbg_we = 1'b0; dbg_req = 1'b1;
    for (int c = 1; c <= 40 && ack_c == 0; c++) begin
      @(negedge clk);
      if (core_rvld) dbg_rvld_n++;
      if (dbg_ack) begin ack_c = c; dbg_req = 1'b0; end
    end
    dbg_req = 1'b0;
    checkOutput("dbgrd_ack_cyc", 32'(ack_c),      32'd4);
    checkOutput("dbgrd_rdata",   32'(dbg_rdata),  32'h3C);
    checkOutput("dbgrd_no_rvld", 32'(dbg_rvld_n), 32'd0);

    // Reset asserted in the middle of the WRITE cycle
    @(negedge clk);
    wr_n = 0; seen = 1'b0;
    status_rp = 2'b00; core_addr7 = 7'h30; core_rd = 1'b0; core_wr = 1'b1;
    core_wdata = 8'hAA; core_wdata_vld = 1'b1; core_req = 1'b1;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (rf_wr_en) seen = 1'b1;
    end
    checkOutput("rstw_reached", 32'(seen), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstw_wr_drop", 32'(rf_wr_en), 32'd0);
    core_req = 1'b0; core_wr = 1'b0; core_wdata_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (core_done) done_cnt++;
    end
    checkOutput("rstw_no_done", 32'(done_cnt),     32'd0);
    checkOutput("rstw_wr_n",    32'(wr_n),         32'd0);
    checkOutput("rstw_mem",     32'(mem[9'h030]),  32'h01);
    checkOutput("rstw_rf_addr", 32'(rf_addr),      32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
